// File: rtl/ifid_stage_reg.sv
// IF/ID pipeline stage register with valid/ready handshake, flush and stall counter.
// Define IFID_SKID_EN for the 2-entry skid buffer with a registered in_ready.
module ifid_stage_reg #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       PC_W     = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_inscode,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inscode,
    output logic [PC_W-1:0]   out_pc,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              ov_q, ov_d;
    logic [DATA_W-1:0] oi_q, oi_d;
    logic [PC_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              deliver;

    assign accept      = in_valid && in_ready;
    assign deliver     = ov_q && out_ready;
    assign out_valid   = ov_q;
    assign out_inscode = oi_q;
    assign out_pc      = op_q;
    assign stall_cnt   = cnt_q;

    // Saturating backpressure counter; clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (ov_q && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef IFID_SKID_EN
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] si_q, si_d;
    logic [PC_W-1:0]   sp_q, sp_d;
    logic              rdy_q, rdy_d;

    assign in_ready = rdy_q;

    // Next-state: main register feeds decode, skid catches the word accepted under backpressure
    always_comb begin
        state_d = state_q;
        oi_d    = oi_q;
        op_d    = op_q;
        si_d    = si_q;
        sp_d    = sp_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    oi_d    = in_inscode;
                    op_d    = in_pc;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    oi_d = in_inscode;
                    op_d = in_pc;
                end else if (accept) begin
                    state_d = ST_FULL;
                    si_d    = in_inscode;
                    sp_d    = in_pc;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                    oi_d    = NOP_WORD;
                    op_d    = '0;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    state_d = ST_ONE;
                    oi_d    = si_q;
                    op_d    = sp_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                oi_d    = NOP_WORD;
                op_d    = '0;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            oi_d    = NOP_WORD;
            op_d    = '0;
        end
        ov_d  = (state_d != ST_EMPTY);
        rdy_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            ov_q    <= 1'b0;
            oi_q    <= NOP_WORD;
            op_q    <= '0;
            si_q    <= '0;
            sp_q    <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            ov_q    <= ov_d;
            oi_q    <= oi_d;
            op_q    <= op_d;
            si_q    <= si_d;
            sp_q    <= sp_d;
            rdy_q   <= rdy_d;
        end
    end
`else
    assign in_ready = !ov_q || out_ready;

    // Single register: load on accept, return to NOP bubble on plain deliver or flush
    always_comb begin
        ov_d = ov_q;
        oi_d = oi_q;
        op_d = op_q;
        if (flush) begin
            ov_d = 1'b0;
            oi_d = NOP_WORD;
            op_d = '0;
        end else if (accept) begin
            ov_d = 1'b1;
            oi_d = in_inscode;
            op_d = in_pc;
        end else if (deliver) begin
            ov_d = 1'b0;
            oi_d = NOP_WORD;
            op_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ov_q <= 1'b0;
            oi_q <= NOP_WORD;
            op_q <= '0;
        end else begin
            ov_q <= ov_d;
            oi_q <= oi_d;
            op_q <= op_d;
        end
    end
`endif

endmodule

// File: tb/tb_ifid_stage_reg.sv
// Scoreboard bench for ifid_stage_reg (CNT_W = 4); follows IFID_SKID_EN when defined.
module tb_ifid_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef IFID_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } word_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inscode;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inscode;
    logic [31:0] out_pc;
    logic        cnt_clr;
    logic [3:0]  stall_cnt;

    word_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_cnt = 0;
    int    acc;

    ifid_stage_reg #(
        .DATA_W  (32),
        .PC_W    (32),
        .NOP_WORD(NOP),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inscode (in_inscode),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inscode(out_inscode),
        .out_pc     (out_pc),
        .cnt_clr    (cnt_clr),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs from posedge+1, return at the following posedge+1
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic clr);
        in_valid   = v;
        in_inscode = ins;
        in_pc      = pc;
        out_ready  = ordy;
        flush      = fl;
        cnt_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    // Reference model sampled mid-cycle; it predicts the state after the next edge
    always @(negedge clk) begin
        logic exp_rdy;
        exp_rdy = SKID ? (q.size() < 2) : ((q.size() == 0) || out_ready);
        if (!rst) begin
            q.delete();
            exp_cnt = 0;
            check("rst_valid", 64'(out_valid), 64'(0));
            check("rst_ins", 64'(out_inscode), 64'(NOP));
            check("rst_pc", 64'(out_pc), 64'(0));
            check("rst_cnt", 64'(stall_cnt), 64'(0));
            check("rst_ready", 64'(in_ready), 64'(1));
        end else begin
            check("valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                check("ins", 64'(out_inscode), 64'(q[0].ins));
                check("pc", 64'(out_pc), 64'(q[0].pc));
            end else begin
                check("nop_ins", 64'(out_inscode), 64'(NOP));
                check("nop_pc", 64'(out_pc), 64'(0));
            end
            check("ready", 64'(in_ready), 64'(exp_rdy));
            check("cnt", 64'(stall_cnt), 64'(exp_cnt));
            if (cnt_clr) exp_cnt = 0;
            else if ((q.size() != 0) && !out_ready && (exp_cnt != 15)) exp_cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if ((q.size() != 0) && out_ready) void'(q.pop_front());
                if (in_valid && exp_rdy) q.push_back('{ins: in_inscode, pc: in_pc});
            end
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_inscode = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Back-to-back stream with decode always ready
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 32'(i), 32'((i - 1) * 4), 1'b1, 1'b0, 1'b0);
            check("stream_valid", 64'(out_valid), 64'(1));
            check("stream_ins", 64'(out_inscode), 64'(i));
        end
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("stream_cnt", 64'(stall_cnt), 64'(0));

        // Five cycles of backpressure
        step(1'b1, 32'hA0, 32'h100, 1'b0, 1'b0, 1'b1);
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_inscode = 32'hB0 + 32'(k); in_pc = 32'h104 + 32'(4 * k);
            out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
            #1;
            if (in_ready) acc++;
            @(posedge clk);
            #1;
            check("stall_hold_ins", 64'(out_inscode), 64'(32'hA0));
            check("stall_hold_pc", 64'(out_pc), 64'(32'h100));
        end
        check("stall_cnt5", 64'(stall_cnt), 64'(5));
        check("stall_accepts", 64'(acc), 64'(SKID ? 1 : 0));
        repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Flush while holding (FULL with skid); the flush-cycle offer is dropped
        step(1'b1, 32'hC0, 32'h200, 1'b0, 1'b0, 1'b0);
        if (SKID) step(1'b1, 32'hC1, 32'h204, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC2, 32'h208, 1'b0, 1'b1, 1'b0);
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_ins", 64'(out_inscode), 64'(NOP));
        check("flush_pc", 64'(out_pc), 64'(0));
        repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Flush on an empty stage with a word accepted in the same cycle
        step(1'b1, 32'hD0, 32'h300, 1'b1, 1'b1, 1'b0);
        check("flush_acc_valid", 64'(out_valid), 64'(0));
        repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("flush_acc_gone", 64'(out_valid), 64'(0));

        // Saturation and clear during stall
        step(1'b1, 32'hE0, 32'h400, 1'b0, 1'b0, 1'b1);
        repeat (20) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("sat_cnt", 64'(stall_cnt), 64'(15));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("clr_cnt", 64'(stall_cnt), 64'(0));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("resume_cnt", 64'(stall_cnt), 64'(1));
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-stream
        step(1'b1, 32'hF0, 32'h500, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hF1, 32'h504, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_ins", 64'(out_inscode), 64'(NOP));
        check("arst_pc", 64'(out_pc), 64'(0));
        check("arst_cnt", 64'(stall_cnt), 64'(0));
        check("arst_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, 32'h2002_0005, 32'h40, 1'b0, 1'b0, 1'b0);
        check("post_rst_valid", 64'(out_valid), 64'(1));
        check("post_rst_ins", 64'(out_inscode), 64'(32'h2002_0005));
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("drained", 64'(q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
